// File: rtl/galvo_pkg.sv
// galvo_pkg: shared FSM encoding, DAC channel codes and SPI word format for the galvo scanner.
package galvo_pkg;
    typedef enum logic [2:0] {IDLE, LOAD_H, SHIFT_H, GAP, LOAD_V, SHIFT_V, SETTLE, DONE} state_t;
    localparam logic [1:0] CH_H = 2'b00;
    localparam logic [1:0] CH_V = 2'b01;
    localparam int SPI_WORD_W = 16;
    localparam int POS_FIELD_W = 11;
    function automatic logic [SPI_WORD_W-1:0] dac_word(input logic [1:0] ch, input logic [POS_FIELD_W-1:0] pos);
        return {ch, 3'b000, pos};
    endfunction
endpackage

// File: rtl/galvo_spi_word.sv
// galvo_spi_word: shifts one 16-bit word out MSB first in SPI mode 0 (SCLK low then high per bit).
module galvo_spi_word import galvo_pkg::*; #(
    parameter int SCLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [SPI_WORD_W-1:0] word_i,
    output logic                  ready_o,
    output logic                  last_o,
    output logic                  cs_n_o,
    output logic                  sclk_o,
    output logic                  mosi_o
);
    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam int BIT_W = $clog2(SPI_WORD_W);
    logic                  active_q;
    logic [DIV_W-1:0]      div_q;
    logic [BIT_W-1:0]      bit_q;
    logic [SPI_WORD_W-1:0] sh_q;
    logic                  sclk_q, cs_n_q, mosi_q;
    logic                  tick, bit_end;
    assign tick    = div_q == DIV_W'(SCLK_DIV - 1);
    assign bit_end = active_q && tick && sclk_q;
    assign last_o  = bit_end && bit_q == BIT_W'(SPI_WORD_W - 1);
    assign ready_o = !active_q;
    assign cs_n_o  = cs_n_q;
    assign sclk_o  = sclk_q;
    assign mosi_o  = mosi_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            mosi_q   <= 1'b0;
        end else if (!active_q) begin
            if (start_i) begin
                active_q <= 1'b1;
                cs_n_q   <= 1'b0;
                sh_q     <= word_i;
                mosi_q   <= word_i[SPI_WORD_W-1];
                div_q    <= '0;
                bit_q    <= '0;
                sclk_q   <= 1'b0;
            end
        end else begin
            div_q <= tick ? '0 : div_q + 1'b1;
            if (tick) sclk_q <= ~sclk_q;
            // MOSI advances on the falling SCLK edge that closes each bit
            if (last_o) begin
                active_q <= 1'b0;
                cs_n_q   <= 1'b1;
                mosi_q   <= 1'b0;
            end else if (bit_end) begin
                bit_q  <= bit_q + 1'b1;
                sh_q   <= {sh_q[SPI_WORD_W-2:0], 1'b0};
                mosi_q <= sh_q[SPI_WORD_W-2];
            end
        end
    end
endmodule

// File: rtl/galvo_scan.sv
// galvo_scan: raster pointer and sequencer writing one (H,V) point per go to the galvo DAC,
// then waiting the settle time before pulsing done.
module galvo_scan import galvo_pkg::*; #(
    parameter int POS_W    = 11,
    parameter int SCLK_DIV = 4,
    parameter int SETTLE_W = 10
) (
    input  logic                clk_adc,
    input  logic                rst_adc,
    input  logic                galvo_go,
    input  logic                enable,
    input  logic                home,
    input  logic [POS_W-1:0]    h_max,
    input  logic [POS_W-1:0]    v_max,
    input  logic [SETTLE_W-1:0] settle_cycles,
    input  logic                overrun_clr,
    output logic [POS_W-1:0]    galvoh,
    output logic [POS_W-1:0]    galvov,
    output logic                galvo_spi_done,
    output logic                frame_done,
    output logic                busy,
    output logic                overrun,
    output logic                spi_cs_n,
    output logic                spi_sclk,
    output logic                spi_mosi
);
    state_t                state_q;
    logic [POS_W-1:0]      ptr_h_q, ptr_v_q, galvoh_q, galvov_q;
    logic [SETTLE_W-1:0]   cnt_q;
    logic                  frame_q, done_q, frame_done_q, busy_q, overrun_q;
    logic                  accept, h_wrap, v_wrap, v_start, to_done;
    logic                  spi_start, spi_ready, spi_last;
    logic [POS_W-1:0]      base_h, base_v, nxt_h, nxt_v;
    logic [SPI_WORD_W-1:0] spi_word;
    assign galvoh         = galvoh_q;
    assign galvov         = galvov_q;
    assign galvo_spi_done = done_q;
    assign frame_done     = frame_done_q;
    assign busy           = busy_q;
    assign overrun        = overrun_q;
    // home in the acceptance cycle makes this point (0,0) and advances from there
    assign accept    = state_q == IDLE && enable && galvo_go;
    assign base_h    = home ? '0 : ptr_h_q;
    assign base_v    = home ? '0 : ptr_v_q;
    assign h_wrap    = base_h >= h_max;
    assign v_wrap    = base_v >= v_max;
    assign nxt_h     = h_wrap ? '0 : base_h + 1'b1;
    assign nxt_v     = h_wrap ? (v_wrap ? '0 : base_v + 1'b1) : base_v;
    assign v_start   = state_q == GAP && cnt_q == '0 && spi_ready;
    assign spi_start = accept || v_start;
    assign spi_word  = v_start ? dac_word(CH_V, POS_FIELD_W'(galvov_q)) : dac_word(CH_H, POS_FIELD_W'(base_h));
    assign to_done   = (state_q == SHIFT_V && spi_last && settle_cycles == '0) || (state_q == SETTLE && cnt_q == '0);
    galvo_spi_word #(.SCLK_DIV(SCLK_DIV)) u_spi (
        .clk     (clk_adc),
        .rst     (rst_adc),
        .start_i (spi_start),
        .word_i  (spi_word),
        .ready_o (spi_ready),
        .last_o  (spi_last),
        .cs_n_o  (spi_cs_n),
        .sclk_o  (spi_sclk),
        .mosi_o  (spi_mosi)
    );
    always_ff @(posedge clk_adc or posedge rst_adc) begin
        if (rst_adc) begin
            state_q      <= IDLE;
            ptr_h_q      <= '0;
            ptr_v_q      <= '0;
            galvoh_q     <= '0;
            galvov_q     <= '0;
            cnt_q        <= '0;
            frame_q      <= 1'b0;
            done_q       <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            done_q       <= to_done;
            frame_done_q <= to_done && frame_q;
            overrun_q    <= (galvo_go && enable && state_q != IDLE) || (overrun_q && !overrun_clr);
            if (accept) begin
                galvoh_q <= base_h;
                galvov_q <= base_v;
                ptr_h_q  <= nxt_h;
                ptr_v_q  <= nxt_v;
                frame_q  <= base_h == h_max && base_v == v_max;
            end else if (home) begin
                ptr_h_q <= '0;
                ptr_v_q <= '0;
            end
            if (accept) busy_q <= 1'b1;
            else if (to_done) busy_q <= 1'b0;
            case (state_q)
                IDLE:    if (accept) state_q <= LOAD_H;
                LOAD_H:  state_q <= SHIFT_H;
                SHIFT_H: if (spi_last) begin
                    state_q <= GAP;
                    cnt_q   <= SETTLE_W'(SCLK_DIV - 1);
                end
                GAP:     if (v_start) state_q <= LOAD_V;
                         else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                LOAD_V:  state_q <= SHIFT_V;
                SHIFT_V: if (spi_last) begin
                    state_q <= to_done ? DONE : SETTLE;
                    cnt_q   <= settle_cycles - 1'b1;
                end
                SETTLE:  if (to_done) state_q <= DONE;
                         else cnt_q <= cnt_q - 1'b1;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
